// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - configuration register file with two-port round-robin arbiter
// Port A (I2C side) may lock the file across bursts; port B is local IO/status logic.
module regfile_arbiter #(
  parameter int REGCOUNT = 24,
  parameter int ADDR_W   = 5,
  parameter int LOCK_MAX = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [7:0]            a_wdata,
  input  logic                  a_lock,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [7:0]            a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [7:0]            b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [7:0]            b_rdata,
  output logic [8*REGCOUNT-1:0] registers_packed,
  output logic                  addr_err,
  output logic                  lock_timeout
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [ADDR_W:0] LP_COUNT = (ADDR_W + 1)'(REGCOUNT);
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(LOCK_MAX - 1);

  typedef enum logic [1:0] {IDLE, SERVE, LOCKED} state_t;

  state_t           r_state;
  logic             r_prefer_b;
  logic [CNT_W-1:0] r_lock_cnt;
  logic [7:0]       r_regs [REGCOUNT];
  logic             r_a_rvalid;
  logic             r_b_rvalid;
  logic [7:0]       r_a_rdata;
  logic [7:0]       r_b_rdata;
  logic             r_addr_err;
  logic             r_lock_timeout;

  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              w_gnt;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_wdata;
  logic              w_in_range;
  logic [7:0]        w_rd_byte;

  // While locked only A can win; otherwise the pointer breaks ties.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (r_state == LOCKED) begin
      w_a_gnt = a_req;
    end else if (a_req && b_req) begin
      w_a_gnt = !r_prefer_b;
      w_b_gnt = r_prefer_b;
    end else begin
      w_a_gnt = a_req;
      w_b_gnt = b_req;
    end
  end

  assign w_gnt      = w_a_gnt || w_b_gnt;
  assign w_we       = w_a_gnt ? a_we    : b_we;
  assign w_addr     = w_a_gnt ? a_addr  : b_addr;
  assign w_wdata    = w_a_gnt ? a_wdata : b_wdata;
  assign w_in_range = ({1'b0, w_addr} < LP_COUNT);
  assign w_rd_byte  = w_in_range ? r_regs[w_addr] : 8'h00;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_prefer_b     <= 1'b0;
      r_lock_cnt     <= '0;
      r_a_rvalid     <= 1'b0;
      r_b_rvalid     <= 1'b0;
      r_a_rdata      <= 8'h00;
      r_b_rdata      <= 8'h00;
      r_addr_err     <= 1'b0;
      r_lock_timeout <= 1'b0;
      for (int i = 0; i < REGCOUNT; i++) r_regs[i] <= 8'h00;
    end else begin
      r_a_rvalid     <= w_a_gnt && !a_we;
      r_b_rvalid     <= w_b_gnt && !b_we;
      r_addr_err     <= w_gnt && !w_in_range;
      r_lock_timeout <= 1'b0;
      if (w_a_gnt && !a_we) r_a_rdata <= w_rd_byte;
      if (w_b_gnt && !b_we) r_b_rdata <= w_rd_byte;
      if (w_gnt && w_we && w_in_range) r_regs[w_addr] <= w_wdata;

      case (r_state)
        IDLE, SERVE: begin
          if (w_a_gnt) begin
            r_prefer_b <= 1'b1;
            if (a_lock) begin
              r_state    <= LOCKED;
              r_lock_cnt <= '0;
            end else begin
              r_state <= SERVE;
            end
          end else if (w_b_gnt) begin
            r_prefer_b <= 1'b0;
            r_state    <= SERVE;
          end else begin
            r_state <= IDLE;
          end
        end
        LOCKED: begin
          if (w_a_gnt) begin
            r_prefer_b <= 1'b1;
            r_lock_cnt <= '0;
            if (!a_lock) r_state <= SERVE;
          end else if (!a_lock) begin
            r_state    <= SERVE;
            r_lock_cnt <= '0;
          end else if (r_lock_cnt == LP_CNT_LAST) begin
            r_state        <= SERVE;
            r_prefer_b     <= 1'b1;
            r_lock_cnt     <= '0;
            r_lock_timeout <= 1'b1;
          end else begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < REGCOUNT; g++) begin : g_pack
    assign registers_packed[8*g +: 8] = r_regs[g];
  end

  assign a_gnt        = w_a_gnt;
  assign b_gnt        = w_b_gnt;
  assign a_rvalid     = r_a_rvalid;
  assign b_rvalid     = r_b_rvalid;
  assign a_rdata      = r_a_rdata;
  assign b_rdata      = r_b_rdata;
  assign addr_err     = r_addr_err;
  assign lock_timeout = r_lock_timeout;

endmodule
